// File: rtl/ofdm_pkg.sv
// Shared OFDM framing types and constants for the preamble inserter.
package ofdm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CP,
        HALF0,
        HALF1,
        PAYLOAD
    } state_t;

    localparam int unsigned DEF_HALF_FFT_SIZE = 512;
    localparam int unsigned DEF_HALPH_CP_SIZE = 64;
    localparam int unsigned CP_SIZE           = 2 * DEF_HALPH_CP_SIZE;
    localparam int unsigned FRAME_OVERHEAD    = CP_SIZE + 2 * DEF_HALF_FFT_SIZE;

    // Cyclic-prefix length for a given half-CP size.
    function automatic int unsigned cp_size(input int unsigned halph_cp);
        return 2 * halph_cp;
    endfunction

    // Preamble beats per frame (CP plus two half-symbols).
    function automatic int unsigned frame_overhead(input int unsigned half_fft,
                                                   input int unsigned halph_cp);
        return cp_size(halph_cp) + 2 * half_fft;
    endfunction

endpackage

// File: rtl/sc_preamble_ram.sv
// Preamble sample RAM: one write port, registered read with 1-cycle latency.
module sc_preamble_ram #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write on demand, read every cycle from the presented address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/sc_preamble_inserter.sv
// Prepends CP + two preamble half-symbols (from RAM) to each payload frame.
module sc_preamble_inserter
    import ofdm_pkg::*;
#(
    parameter int unsigned HALF_FFT_SIZE = 512,
    parameter int unsigned HALPH_CP_SIZE = 64
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic [31:0]                      packet_length,
    input  logic                             bypass,
    input  logic                             cfg_we,
    input  logic [$clog2(HALF_FFT_SIZE)-1:0] cfg_addr,
    input  logic [31:0]                      cfg_wdata,
    input  logic [31:0]                      i_tdata,
    input  logic                             i_tlast,
    input  logic                             i_tvalid,
    output logic                             i_tready,
    output logic [31:0]                      o_tdata,
    output logic                             o_tlast,
    output logic                             o_tvalid,
    input  logic                             o_tready
);

    localparam int unsigned  AW        = $clog2(HALF_FFT_SIZE);
    localparam int unsigned  CP_LEN    = cp_size(HALPH_CP_SIZE);
    localparam logic [AW-1:0] CP_BASE   = AW'(HALF_FFT_SIZE - CP_LEN);
    localparam logic [AW-1:0] CP_LAST   = AW'(CP_LEN - 1);
    localparam logic [AW-1:0] HALF_LAST = AW'(HALF_FFT_SIZE - 1);

    state_t        state;
    logic [AW-1:0] samp_cnt;
    logic [31:0]   pay_len;
    logic [31:0]   pay_cnt;

    logic [31:0]   head_data, skid_data;
    logic          head_valid, head_last, skid_valid, skid_last;

    logic [AW-1:0] rd_addr;
    logic [31:0]   ram_rdata;
    logic          has_space, bypass_act, pay_left, start, pop;
    logic          wr_en, wr_last;
    logic [31:0]   wr_data;

    // Bypass only engages between frames once buffered beats have drained.
    assign bypass_act = (state == IDLE) && bypass && !head_valid;
    assign has_space  = !skid_valid;
    assign pay_left   = pay_cnt < pay_len;
    assign pop        = head_valid && o_tready;
    assign start      = (state == IDLE) && !bypass && i_tvalid && (packet_length != '0);

    sc_preamble_ram #(
        .DEPTH (HALF_FFT_SIZE),
        .AW    (AW),
        .DW    (32)
    ) u_ram (
        .clk   (clk),
        .we    (cfg_we && (state == IDLE)),
        .waddr (cfg_addr),
        .wdata (cfg_wdata),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Select the beat source and decide whether it enters the buffer this cycle.
    always_comb begin
        wr_en   = 1'b0;
        wr_last = 1'b0;
        wr_data = ram_rdata;
        unique case (state)
            CP, HALF0, HALF1: wr_en = has_space;
            PAYLOAD: begin
                wr_en   = has_space && pay_left && i_tvalid;
                wr_data = i_tdata;
                wr_last = (pay_cnt == pay_len - 32'd1);
            end
            default: ;
        endcase
    end

    // RAM address for the beat after this one: the read result must be ready
    // on the cycle that beat is written, so the address leads by one cycle.
    always_comb begin
        rd_addr = CP_BASE;
        unique case (state)
            CP: begin
                if (!wr_en)                   rd_addr = CP_BASE + samp_cnt;
                else if (samp_cnt == CP_LAST) rd_addr = '0;
                else                          rd_addr = CP_BASE + samp_cnt + 1'b1;
            end
            HALF0: begin
                if (!wr_en)                     rd_addr = samp_cnt;
                else if (samp_cnt == HALF_LAST) rd_addr = '0;
                else                            rd_addr = samp_cnt + 1'b1;
            end
            HALF1: begin
                if (!wr_en)                     rd_addr = samp_cnt;
                else if (samp_cnt == HALF_LAST) rd_addr = CP_BASE;
                else                            rd_addr = samp_cnt + 1'b1;
            end
            default: ;
        endcase
    end

    // Frame sequencer: counters advance only on buffer writes.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= IDLE;
            samp_cnt <= '0;
            pay_cnt  <= '0;
            pay_len  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        pay_len  <= packet_length;
                        samp_cnt <= '0;
                        pay_cnt  <= '0;
                        state    <= CP;
                    end
                end
                CP: begin
                    if (wr_en) begin
                        if (samp_cnt == CP_LAST) begin
                            samp_cnt <= '0;
                            state    <= HALF0;
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                HALF0: begin
                    if (wr_en) begin
                        if (samp_cnt == HALF_LAST) begin
                            samp_cnt <= '0;
                            state    <= HALF1;
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                HALF1: begin
                    if (wr_en) begin
                        if (samp_cnt == HALF_LAST) begin
                            samp_cnt <= '0;
                            pay_cnt  <= '0;
                            state    <= PAYLOAD;
                        end else begin
                            samp_cnt <= samp_cnt + 1'b1;
                        end
                    end
                end
                PAYLOAD: begin
                    if (wr_en) begin
                        if (wr_last) begin
                            pay_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            pay_cnt <= pay_cnt + 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Two-entry skid buffer; the head entry drives the outputs directly.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            head_valid <= 1'b0;
            head_last  <= 1'b0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
        end else begin
            unique case ({wr_en, pop})
                2'b10: begin
                    if (!head_valid) begin
                        head_data  <= wr_data;
                        head_last  <= wr_last;
                        head_valid <= 1'b1;
                    end else begin
                        skid_data  <= wr_data;
                        skid_last  <= wr_last;
                        skid_valid <= 1'b1;
                    end
                end
                2'b01: begin
                    if (skid_valid) begin
                        head_data  <= skid_data;
                        head_last  <= skid_last;
                        skid_valid <= 1'b0;
                        skid_last  <= 1'b0;
                    end else begin
                        head_valid <= 1'b0;
                        head_last  <= 1'b0;
                    end
                end
                2'b11: begin
                    if (skid_valid) begin
                        head_data <= skid_data;
                        head_last <= skid_last;
                        skid_data <= wr_data;
                        skid_last <= wr_last;
                    end else begin
                        head_data <= wr_data;
                        head_last <= wr_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tdata  = bypass_act ? i_tdata  : head_data;
    assign o_tlast  = bypass_act ? i_tlast  : head_last;
    assign o_tvalid = bypass_act ? i_tvalid : head_valid;
    assign i_tready = bypass_act ? o_tready : ((state == PAYLOAD) && has_space && pay_left);

endmodule

// File: tb/tb_sc_preamble_inserter.sv
// Scoreboard bench for sc_preamble_inserter (HALF_FFT_SIZE=8, HALPH_CP_SIZE=2).
module tb_sc_preamble_inserter;

    localparam int HALF = 8;
    localparam int HCP  = 2;
    localparam int CPL  = 2 * HCP;

    logic        clk = 1'b0;
    logic        reset, clear, bypass, cfg_we;
    logic [31:0] packet_length, cfg_wdata, i_tdata, o_tdata;
    logic [2:0]  cfg_addr;
    logic        i_tlast, i_tvalid, i_tready, o_tlast, o_tvalid, o_tready;

    typedef struct packed {
        logic        last;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [31:0] tdata;
        logic        tlast;
        logic        tvalid;
        logic        tready;
        logic [31:0] exp_tdata;
        logic        exp_tlast;
        logic        exp_tvalid;
        logic        exp_i_tready;
    } byp_vec_t;

    typedef struct {
        int          len;
        logic [31:0] base;
        int          stall_at;
        bit          rnd;
        int          exp_gap;
    } frame_vec_t;

    beat_t       exp_q[$];
    logic [31:0] ram_m [HALF];
    int          total = 0;
    int          bad   = 0;
    int          xfer_cnt = 0;
    int          gap_run = 0;
    int          last_gap = 0;
    bit          mon_en = 1'b1;
    bit          rnd_ready = 1'b0;
    logic        ready_fixed = 1'b1;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    sc_preamble_inserter #(
        .HALF_FFT_SIZE (HALF),
        .HALPH_CP_SIZE (HCP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .clear         (clear),
        .packet_length (packet_length),
        .bypass        (bypass),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_wdata     (cfg_wdata),
        .i_tdata       (i_tdata),
        .i_tlast       (i_tlast),
        .i_tvalid      (i_tvalid),
        .i_tready      (i_tready),
        .o_tdata       (o_tdata),
        .o_tlast       (o_tlast),
        .o_tvalid      (o_tvalid),
        .o_tready      (o_tready)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sole driver of o_tready: random when requested, otherwise a fixed level.
    initial begin
        o_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            o_tready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
        end
    end

    // Output monitor: scoreboard compare, stall stability, gap tracking.
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall)
                chk("stall_hold", {o_tvalid, o_tlast, o_tdata}, {1'b1, prev_last, prev_data});
            if (o_tvalid && o_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_beat: got 0x%0h want none", o_tdata);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("beat%0d", xfer_cnt), {o_tlast, o_tdata}, {e.last, e.data});
                end
                xfer_cnt++;
            end
            if (!o_tvalid) begin
                gap_run++;
            end else begin
                if (gap_run > 0) last_gap = gap_run;
                gap_run = 0;
            end
            prev_stall = o_tvalid && !o_tready;
            prev_data  = o_tdata;
            prev_last  = o_tlast;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic push_preamble();
        for (int i = HALF - CPL; i < HALF; i++) exp_q.push_back({1'b0, ram_m[i]});
        for (int h = 0; h < 2; h++)
            for (int i = 0; i < HALF; i++) exp_q.push_back({1'b0, ram_m[i]});
    endtask

    task automatic send_frame(input int len, input logic [31:0] base, input int stall_at);
        int   i;
        int   budget;
        logic acc;
        packet_length = len;
        push_preamble();
        for (int k = 0; k < len; k++) exp_q.push_back({(k == len - 1), base + 32'(k)});
        i = 0;
        budget = 0;
        i_tdata = base;
        i_tvalid = 1'b1;
        while (i < len && budget < 2000) begin
            @(negedge clk);
            acc = i_tvalid && i_tready;
            cyc();
            budget++;
            if (acc) begin
                i++;
                if (i == stall_at) begin
                    i_tvalid = 1'b0;
                    repeat (3) cyc();
                end
                i_tdata  = base + 32'(i);
                i_tvalid = (i < len);
            end
        end
        i_tvalid = 1'b0;
        chk("payload_accepted", 64'(i), 64'(len));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 3000) begin
            cyc();
            n++;
        end
        chk("queue_left", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        repeat (2) cyc();
    endtask

    initial begin
        byp_vec_t   bv [4];
        frame_vec_t fv [5];
        int         base_x;
        int         n;

        bv[0] = '{32'h1234_5678, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1};
        bv[1] = '{32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0};
        bv[2] = '{32'h0000_0000, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        bv[3] = '{32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1};

        fv[0] = '{5, 32'hA0, -1, 1'b0, 0};
        fv[1] = '{5, 32'hA0, -1, 1'b1, 0};
        fv[2] = '{6, 32'h60, 3,  1'b0, 3};
        fv[3] = '{1, 32'h70, -1, 1'b0, 0};
        fv[4] = '{9, 32'h80, -1, 1'b1, 0};

        reset = 1'b1; clear = 1'b0; bypass = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_wdata = '0; packet_length = 32'd5;
        i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
        repeat (3) cyc();
        reset = 1'b0;
        chk("rst_o_tvalid", o_tvalid, 1'b0);
        chk("rst_o_tlast", o_tlast, 1'b0);
        chk("rst_i_tready", i_tready, 1'b0);

        for (int a = 0; a < HALF; a++) begin
            ram_m[a]  = 32'h10 + 32'(a);
            cfg_we    = 1'b1;
            cfg_addr  = 3'(a);
            cfg_wdata = ram_m[a];
            cyc();
        end
        cfg_we = 1'b0;
        cyc();

        // Basic frame with first-beat latency check.
        fork
            send_frame(5, 32'hA0, -1);
            begin
                cyc();
                chk("lat_after_start_edge", o_tvalid, 1'b0);
                cyc();
                chk("lat_first_beat", {o_tvalid, o_tdata}, {1'b1, 32'h14});
            end
        join
        drain();

        // Table of frames: plain, backpressure, starvation, single beat, long.
        for (int f = 0; f < 5; f++) begin
            rnd_ready = fv[f].rnd;
            last_gap  = 0;
            send_frame(fv[f].len, fv[f].base, fv[f].stall_at);
            drain();
            rnd_ready = 1'b0;
            if (fv[f].exp_gap != 0) chk("starve_gap", 64'(last_gap), 64'(fv[f].exp_gap));
        end

        // Reset at beat 10 aborts the frame.
        packet_length = 32'd5;
        push_preamble();
        base_x = xfer_cnt;
        i_tdata = 32'hB0;
        i_tvalid = 1'b1;
        n = 0;
        while (xfer_cnt - base_x < 10 && n < 300) begin
            cyc();
            n++;
        end
        chk("reach_beat10", 64'(xfer_cnt - base_x >= 10), 64'd1);
        reset = 1'b1;
        i_tvalid = 1'b0;
        cyc();
        reset = 1'b0;
        chk("abort_o_tvalid", o_tvalid, 1'b0);
        chk("abort_o_tlast", o_tlast, 1'b0);
        chk("abort_i_tready", i_tready, 1'b0);
        exp_q.delete();
        cyc();
        send_frame(5, 32'hA0, -1);
        drain();

        // RAM write and bypass toggles during a frame are ignored.
        base_x = xfer_cnt;
        fork
            send_frame(4, 32'hC0, -1);
            begin
                n = 0;
                while (xfer_cnt - base_x < 6 && n < 300) begin
                    cyc();
                    n++;
                end
                cfg_we = 1'b1; cfg_addr = 3'd0; cfg_wdata = 32'hFF; bypass = 1'b1;
                cyc();
                cfg_we = 1'b0;
                repeat (2) cyc();
                bypass = 1'b0;
            end
        join
        drain();
        send_frame(3, 32'hD0, -1);
        drain();

        // Zero-length packets never start a frame.
        packet_length = 32'd0;
        i_tvalid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            chk("len0_i_tready", i_tready, 1'b0);
            chk("len0_o_tvalid", o_tvalid, 1'b0);
        end
        i_tvalid = 1'b0;
        cyc();

        // Bypass vectors: combinational mirror.
        mon_en = 1'b0;
        bypass = 1'b1;
        cyc();
        for (int v = 0; v < 4; v++) begin
            ready_fixed = bv[v].tready;
            cyc();
            #1;
            i_tdata  = bv[v].tdata;
            i_tlast  = bv[v].tlast;
            i_tvalid = bv[v].tvalid;
            #1;
            chk($sformatf("bypass_vec%0d", v), {o_tdata, o_tlast, o_tvalid, i_tready},
                {bv[v].exp_tdata, bv[v].exp_tlast, bv[v].exp_tvalid, bv[v].exp_i_tready});
        end
        i_tvalid = 1'b0;
        i_tlast = 1'b0;
        bypass = 1'b0;
        ready_fixed = 1'b1;
        repeat (2) cyc();
        mon_en = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sc_preamble_inserter.md
SC_PREAMBLE_INSERTER -- requirements
Module: sc_preamble_inserter

Interface
REQ-001 SHALL have parameter HALF_FFT_SIZE, default 512, meaning samples per preamble half-symbol.
REQ-002 SHALL have parameter HALPH_CP_SIZE, default 64, meaning half the cyclic-prefix length; CP_SIZE = 2*HALPH_CP_SIZE, required <= HALF_FFT_SIZE.
REQ-003 SHALL have port clk, input, 1, clock.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port clear, input, 1, synchronous soft reset with the same effect as reset, RAM excluded.
REQ-006 SHALL have port packet_length, input, 32, payload samples per frame.
REQ-007 SHALL have port bypass, input, 1, where 1 passes i_* straight to o_* with no preamble inserted.
REQ-008 SHALL have ports cfg_we (input, 1), cfg_addr (input, clog2(HALF_FFT_SIZE)) and cfg_wdata (input, 32), forming the preamble RAM write port.
REQ-009 SHALL have ports i_tdata (in, 32), i_tlast (in, 1), i_tvalid (in, 1) and i_tready (out, 1), the payload AXI-Stream input with sc16 samples.
REQ-010 SHALL have ports o_tdata (out, 32), o_tlast (out, 1), o_tvalid (out, 1) and o_tready (in, 1), the framed AXI-Stream output.

Function
REQ-011 SHALL implement states IDLE, CP, HALF0, HALF1, PAYLOAD.
REQ-012 In IDLE with bypass=0, i_tvalid=1 and packet_length>0 SHALL latch packet_length and move to CP; i_tready=0 in IDLE.
REQ-013 With packet_length=0 SHALL stay in IDLE and never assert i_tready.
REQ-014 CP SHALL emit RAM[HALF_FFT_SIZE-CP_SIZE .. HALF_FFT_SIZE-1] in order, then go to HALF0.
REQ-015 HALF0 and HALF1 SHALL each emit RAM[0 .. HALF_FFT_SIZE-1] in order.
REQ-016 PAYLOAD SHALL forward exactly the latched number of i_* beats, then return to IDLE.
REQ-017 o_tlast SHALL be 1 only on the final payload beat; input i_tlast SHALL be ignored when bypass=0.
REQ-018 Each frame SHALL consist of CP_SIZE + 2*HALF_FFT_SIZE + packet_length beats, in exactly that order.
REQ-019 Output SHALL pass through a 2-entry skid buffer, with o_tdata, o_tvalid and o_tlast registered.
REQ-020 The first CP beat SHALL present o_tvalid on the 2nd clk after the IDLE->CP transition.
REQ-021 When o_tready is held at 1, there SHALL be no bubbles between CP, HALF0, HALF1 and PAYLOAD, provided i_tvalid stays 1.
REQ-022 i_tready SHALL be 1 only when the state is PAYLOAD, the buffer has a free slot, and payload beats remain.
REQ-023 When o_tready=0, o_tdata, o_tvalid and o_tlast SHALL stay stable.
REQ-024 Phase and sample counters SHALL advance only on a buffer write, and the RAM read address SHALL be prefetched one cycle ahead.
REQ-025 A payload-count compare SHALL use 32-bit unsigned arithmetic, with no wrap-around for packet_length up to 2^32-1.
REQ-026 cfg_we SHALL write RAM[cfg_addr] only in IDLE; writes in any other state SHALL be ignored.
REQ-027 bypass SHALL be sampled only in IDLE; a change mid-frame SHALL take effect after the frame ends.
REQ-028 With bypass=1, o_*=i_* and i_tready=o_tready SHALL hold combinationally.

Reset
REQ-029 On reset or clear, the state SHALL be IDLE, all counters 0, the skid buffer empty, and o_tvalid, o_tlast and i_tready 0.
REQ-030 Reset or clear mid-frame SHALL abort the frame immediately, with no tlast emitted.
REQ-031 RAM contents SHALL be preserved across reset and clear.

Structure
REQ-032 The state enum and the CP_SIZE and FRAME_OVERHEAD (CP_SIZE+2*HALF_FFT_SIZE) constants SHALL live in shared package ofdm_pkg.
REQ-033 The preamble RAM SHALL be a sub-module sc_preamble_ram: single-port write, synchronous read with 1-cycle latency, inferrable as block RAM.

Verification
Bench parameters: HALF_FFT_SIZE=8, HALPH_CP_SIZE=2.
REQ-034 Basic frame: RAM=0x10..0x17, packet_length=5, payload 0xA0..0xA4, o_tready=1 -> 25 beats: 0x14..0x17, 0x10..0x17, 0x10..0x17, 0xA0..0xA4, with tlast only on 0xA4.
REQ-035 Backpressure: same frame with o_tready toggling randomly at 50% -> identical 25-beat sequence, and outputs stable while stalled.
REQ-036 Payload starvation: i_tvalid deasserted for 3 cycles mid-payload -> o_tvalid gaps of 3 cycles, no beat lost or duplicated.
REQ-037 Reset mid-frame: reset pulsed at beat 10 -> o_tvalid=0 the next cycle; a new frame then restarts at 0x14 with the RAM unchanged.
REQ-038 Illegal config: cfg_we during HALF0 writing 0xFF to addr 0 -> the current and next frames still emit 0x10 at HALF0 index 0.
REQ-039 Edge modes: packet_length=0 -> i_tready stays 0 and there is no output; bypass=1 -> i_* mirrored to o_* on the same cycle, i_tlast included.
